// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage RV32 pipeline: load-use stalls,
// data-memory freezes with timeout, multi-cycle front-end flush, statistics.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int FLUSH_CYCLES   = 2,
   parameter int TIMEOUT        = 16,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
   input  logic                      id_rs1_used,
   input  logic                      id_rs2_used,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_wreg_addr,
   input  logic                      ex_jump,
   input  logic                      dmem_req,
   input  logic                      dmem_ready,
   input  logic                      clr_cnt,
   output logic                      pc_hold,
   output logic                      if_id_hold,
   output logic                      if_id_flush,
   output logic                      id_ex_hold,
   output logic                      id_ex_bubble,
   output logic                      ex_mem_hold,
   output logic                      mem_wb_bubble,
   output logic [1:0]                state_o,
   output logic                      timeout_err,
   output logic [CNT_WIDTH-1:0]      stall_cycles,
   output logic [CNT_WIDTH-1:0]      flush_events
);

   localparam int WAIT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int FCNT_W      = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
   localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_e;

   function automatic logic src_hit(input logic                      used,
                                    input logic [REG_ADDR_WIDTH-1:0] src,
                                    input logic [REG_ADDR_WIDTH-1:0] dst);
      return used & (src == dst);
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      logic [CNT_WIDTH-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   state_e                state_q, state_d;
   logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [CNT_WIDTH-1:0]  stall_q, stall_d;
   logic [CNT_WIDTH-1:0]  flush_q, flush_d;

   logic mem_busy_s;
   logic load_use_s;
   logic wait_expired_s;
   logic flush_accept_s;
   logic pc_hold_s, if_id_hold_s, if_id_flush_s, id_ex_hold_s;
   logic id_ex_bubble_s, ex_mem_hold_s, mem_wb_bubble_s;

   assign mem_busy_s     = dmem_req & ~dmem_ready;
   assign load_use_s     = ex_mem_read & (ex_wreg_addr != {REG_ADDR_WIDTH{1'b0}}) &
                           (src_hit(id_rs1_used, id_rs1, ex_wreg_addr) |
                            src_hit(id_rs2_used, id_rs2, ex_wreg_addr));
   assign wait_expired_s = (wait_cnt_q == WAIT_W'(TIMEOUT));

   // Next-state and raw pipeline-control decode.
   always_comb begin
      state_d         = state_q;
      fcnt_d          = fcnt_q;
      wait_cnt_d      = wait_cnt_q;
      timeout_err_d   = timeout_err_q;
      flush_accept_s  = 1'b0;
      pc_hold_s       = 1'b0;
      if_id_hold_s    = 1'b0;
      if_id_flush_s   = 1'b0;
      id_ex_hold_s    = 1'b0;
      id_ex_bubble_s  = 1'b0;
      ex_mem_hold_s   = 1'b0;
      mem_wb_bubble_s = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_busy_s) begin
               pc_hold_s       = 1'b1;
               if_id_hold_s    = 1'b1;
               id_ex_hold_s    = 1'b1;
               ex_mem_hold_s   = 1'b1;
               mem_wb_bubble_s = 1'b1;
               wait_cnt_d      = WAIT_W'(1);
               state_d         = ST_MEM_WAIT;
            end else if (ex_jump) begin
               if_id_flush_s  = 1'b1;
               id_ex_bubble_s = 1'b1;
               flush_accept_s = 1'b1;
               wait_cnt_d     = {WAIT_W{1'b0}};
               if (MULTI_FLUSH) begin
                  fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (load_use_s) begin
               pc_hold_s      = 1'b1;
               if_id_hold_s   = 1'b1;
               id_ex_bubble_s = 1'b1;
               wait_cnt_d     = {WAIT_W{1'b0}};
            end else begin
               wait_cnt_d = {WAIT_W{1'b0}};
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               wait_cnt_d = {WAIT_W{1'b0}};
               state_d    = ST_RUN;
            end else if (wait_expired_s) begin
               // Access is abandoned: only the MEM/WB result is squashed.
               timeout_err_d   = 1'b1;
               mem_wb_bubble_s = 1'b1;
               wait_cnt_d      = {WAIT_W{1'b0}};
               state_d         = ST_RUN;
            end else begin
               pc_hold_s       = 1'b1;
               if_id_hold_s    = 1'b1;
               id_ex_hold_s    = 1'b1;
               ex_mem_hold_s   = 1'b1;
               mem_wb_bubble_s = 1'b1;
               wait_cnt_d      = wait_cnt_q + WAIT_W'(1);
            end
         end
         ST_FLUSH: begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
            if (mem_busy_s && !wait_expired_s) begin
               pc_hold_s       = 1'b1;
               ex_mem_hold_s   = 1'b1;
               mem_wb_bubble_s = 1'b1;
               wait_cnt_d      = wait_cnt_q + WAIT_W'(1);
            end else begin
               if (mem_busy_s) begin
                  timeout_err_d   = 1'b1;
                  mem_wb_bubble_s = 1'b1;
               end else begin
                  timeout_err_d = timeout_err_q;
               end
               wait_cnt_d = {WAIT_W{1'b0}};
               fcnt_d     = fcnt_q - FCNT_W'(1);
               if (fcnt_q == FCNT_W'(1)) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_FLUSH;
               end
            end
         end
         default: begin
            state_d    = ST_RUN;
            fcnt_d     = {FCNT_W{1'b0}};
            wait_cnt_d = {WAIT_W{1'b0}};
         end
      endcase
   end

   // Controls are forced inactive while reset is asserted.
   always_comb begin
      pc_hold       = pc_hold_s       & ~rst;
      if_id_hold    = if_id_hold_s    & ~rst;
      if_id_flush   = if_id_flush_s   & ~rst;
      id_ex_hold    = id_ex_hold_s    & ~rst;
      id_ex_bubble  = id_ex_bubble_s  & ~rst;
      ex_mem_hold   = ex_mem_hold_s   & ~rst;
      mem_wb_bubble = mem_wb_bubble_s & ~rst;
   end

   // Saturating statistics; clear has priority over counting.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (clr_cnt) begin
         stall_d = {CNT_WIDTH{1'b0}};
         flush_d = {CNT_WIDTH{1'b0}};
      end else begin
         if (pc_hold) begin
            stall_d = sat_inc(stall_q);
         end else begin
            stall_d = stall_q;
         end
         if (flush_accept_s) begin
            flush_d = sat_inc(flush_q);
         end else begin
            flush_d = flush_q;
         end
      end
   end

   // State, counters and sticky error register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         fcnt_q        <= {FCNT_W{1'b0}};
         wait_cnt_q    <= {WAIT_W{1'b0}};
         timeout_err_q <= 1'b0;
         stall_q       <= {CNT_WIDTH{1'b0}};
         flush_q       <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q       <= state_d;
         fcnt_q        <= fcnt_d;
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
         stall_q       <= stall_d;
         flush_q       <= flush_d;
      end
   end

   assign state_o      = state_q;
   assign timeout_err  = timeout_err_q;
   assign stall_cycles = stall_q;
   assign flush_events = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector table plus hand sequences for pipe_hazard_ctrl
// (FLUSH_CYCLES=2, TIMEOUT=4, 4-bit counters so saturation is reachable).
module tb_pipe_hazard_ctrl;

   localparam int RAW = 5;
   localparam int CW  = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [RAW-1:0] id_rs1, id_rs2, ex_wreg_addr;
   logic           id_rs1_used, id_rs2_used, ex_mem_read, ex_jump;
   logic           dmem_req, dmem_ready, clr_cnt;
   logic           pc_hold, if_id_hold, if_id_flush, id_ex_hold;
   logic           id_ex_bubble, ex_mem_hold, mem_wb_bubble;
   logic [1:0]     state_o;
   logic           timeout_err;
   logic [CW-1:0]  stall_cycles, flush_events;

   pipe_hazard_ctrl #(
      .REG_ADDR_WIDTH(RAW), .FLUSH_CYCLES(2), .TIMEOUT(4), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_mem_read(ex_mem_read), .ex_wreg_addr(ex_wreg_addr),
      .ex_jump(ex_jump), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .clr_cnt(clr_cnt),
      .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
      .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble),
      .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble),
      .state_o(state_o), .timeout_err(timeout_err),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clk = ~clk;

   // Output bundle order: pc_hold, if_id_hold, if_id_flush, id_ex_hold,
   // id_ex_bubble, ex_mem_hold, mem_wb_bubble
   localparam logic [6:0] O_NONE   = 7'b0000000;
   localparam logic [6:0] O_LU     = 7'b1100100;
   localparam logic [6:0] O_FLUSH  = 7'b0010100;
   localparam logic [6:0] O_FREEZE = 7'b1101011;
   localparam logic [6:0] O_FL_MEM = 7'b1010111;
   localparam logic [6:0] O_TMO    = 7'b0000001;

   typedef struct {
      logic [RAW-1:0] rs1;
      logic [RAW-1:0] rs2;
      logic           u1;
      logic           u2;
      logic           mr;
      logic [RAW-1:0] wa;
      logic           jmp;
      logic           req;
      logic           rdy;
      logic [6:0]     exp_o;
      logic [1:0]     exp_st;
   } vec_t;

   vec_t vecs[30];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] outs();
      return {pc_hold, if_id_hold, if_id_flush, id_ex_hold,
              id_ex_bubble, ex_mem_hold, mem_wb_bubble};
   endfunction

   task automatic drive(input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                        input logic u1, input logic u2, input logic mr,
                        input logic [RAW-1:0] wa, input logic jmp,
                        input logic req, input logic rdy);
      id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
      ex_mem_read = mr; ex_wreg_addr = wa; ex_jump = jmp;
      dmem_req = req; dmem_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            rs1    rs2    u1    u2    mr    wa     jmp   req   rdy   outputs   state
      vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};
      vecs[1]  = '{5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU,     2'd0};
      vecs[2]  = '{5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};
      vecs[3]  = '{5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};
      vecs[4]  = '{5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU,     2'd0};
      vecs[5]  = '{5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};
      vecs[6]  = '{5'd9, 5'd2, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};
      vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_FLUSH,  2'd0};
      vecs[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_FLUSH,  2'd2};
      vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};
      vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FREEZE, 2'd0};
      vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FREEZE, 2'd1};
      vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FREEZE, 2'd1};
      vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_NONE,   2'd1};
      vecs[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};
      vecs[15] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FREEZE, 2'd0};
      vecs[16] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FREEZE, 2'd1};
      vecs[17] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FREEZE, 2'd1};
      vecs[18] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FREEZE, 2'd1};
      vecs[19] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_TMO,    2'd1};
      vecs[20] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};
      vecs[21] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, O_FREEZE, 2'd0};
      vecs[22] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, O_NONE,   2'd1};
      vecs[23] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_FLUSH,  2'd0};
      vecs[24] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_FLUSH,  2'd2};
      vecs[25] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};
      vecs[26] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_FLUSH,  2'd0};
      vecs[27] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FL_MEM, 2'd2};
      vecs[28] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_FLUSH,  2'd2};
      vecs[29] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE,   2'd0};

      // Reset with a live load-use hazard on the inputs: controls must stay low.
      rst = 1'b1;
      clr_cnt = 1'b0;
      drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      #2;
      chk("rst_outs", 32'(outs()), 32'(O_NONE));
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_flush", 32'(flush_events), 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);
      tick();
      rst = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         tick();
         drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].mr,
               vecs[i].wa, vecs[i].jmp, vecs[i].req, vecs[i].rdy);
         #2;
         chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_o));
         chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].exp_st));
      end
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("tbl_stall", 32'(stall_cycles), 32'd11);
      chk("tbl_flush", 32'(flush_events), 32'd3);
      chk("tbl_tmo", 32'(timeout_err), 32'd1);

      // Clear coincides with a stall cycle: clear must win.
      tick();
      clr_cnt = 1'b1;
      drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      #2;
      chk("clr_lu_hold", 32'(pc_hold), 32'd1);
      tick();
      clr_cnt = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("clr_stall", 32'(stall_cycles), 32'd0);
      chk("clr_flush", 32'(flush_events), 32'd0);
      chk("tmo_sticky", 32'(timeout_err), 32'd1);

      // Three-cycle memory wait, released on ready.
      for (int i = 0; i < 3; i++) begin
         tick();
         drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
         #2;
         chk($sformatf("mw%0d_outs", i), 32'(outs()), 32'(O_FREEZE));
      end
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      #2;
      chk("mw_rdy_outs", 32'(outs()), 32'(O_NONE));
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("mw_stall", 32'(stall_cycles), 32'd3);
      chk("mw_state", 32'(state_o), 32'd0);

      // Saturation of the 4-bit stall counter.
      for (int i = 0; i < 20; i++) begin
         tick();
         drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      end
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("sat_stall", 32'(stall_cycles), 32'd15);

      // Asynchronous reset in MEM_WAIT with wait_cnt=2.
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      #2;
      chk("pre_rst_state", 32'(state_o), 32'd1);
      chk("pre_rst_outs", 32'(outs()), 32'(O_FREEZE));
      rst = 1'b1;
      #1;
      chk("arst_outs", 32'(outs()), 32'(O_NONE));
      chk("arst_state", 32'(state_o), 32'd0);
      chk("arst_stall", 32'(stall_cycles), 32'd0);
      chk("arst_tmo", 32'(timeout_err), 32'd0);
      tick();
      rst = 1'b0;
      drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      #2;
      chk("post_rst_lu", 32'(outs()), 32'(O_LU));
      chk("post_rst_state", 32'(state_o), 32'd0);

      // Full timeout after reset proves the wait counter restarted.
      for (int i = 0; i < 4; i++) begin
         tick();
         drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
         #2;
         chk($sformatf("to%0d_outs", i), 32'(outs()), 32'(O_FREEZE));
      end
      tick();
      #2;
      chk("to_bubble_only", 32'(outs()), 32'(O_TMO));
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("to_err", 32'(timeout_err), 32'd1);
      chk("to_state", 32'(state_o), 32'd0);
      chk("to_stall", 32'(stall_cycles), 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
